// File: rtl/cart_loader.sv
// rtl/cart_loader.sv - ioctl ROM download to sdram byte writer with cart address masking; optional checksum via CART_LOADER_CHECKSUM_EN
module cart_loader #(
  parameter int         AW       = 22,
  parameter logic [7:0] CODE_IDX = 8'd3,
  parameter logic [4:0] GG_IDX   = 5'd2
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          ioctl_download,
  input  logic [7:0]    ioctl_index,
  input  logic          ioctl_wr,
  input  logic [24:0]   ioctl_addr,
  input  logic [7:0]    ioctl_dout,
  output logic          ioctl_wait,
  output logic [AW-1:0] mem_waddr,
  output logic [7:0]    mem_din,
  output logic          mem_we,
  input  logic          mem_we_ack,
  input  logic [AW-1:0] rom_addr,
  output logic [AW-1:0] mem_raddr,
  output logic          cart_dl,
  output logic          gg,
  output logic          header,
`ifdef CART_LOADER_CHECKSUM_EN
  output logic [15:0]   checksum,
`endif
  output logic          load_done
);

  typedef enum logic [2:0] {S_DRAIN, S_IDLE, S_LOAD, S_ACK, S_FINISH} state_t;

  state_t          state_q, state_d;
  logic            cart_dl_q;
  logic            ioctl_wait_q;
  logic [AW-1:0]   mem_waddr_q;
  logic [7:0]      mem_din_q;
  logic            mem_we_q;
  logic            gg_q;
  logic            header_q;
  logic            load_done_q;
  logic [AW-1:0]   cart_mask_q;
  logic [AW-1:0]   cart_mask512_q;
  logic [9:0]      byte_cnt_q;
  logic            fall_pend_q;

  logic            start, accept, acked, finish;
  logic            dl_rise, dl_fall, we_match, header_hit;
  logic [AW-1:0]   addr_lo, addr_m512, rd_off;

  assign cart_dl    = ioctl_download & (ioctl_index != CODE_IDX);
  assign dl_rise    = cart_dl & ~cart_dl_q;
  assign dl_fall    = ~cart_dl & cart_dl_q;
  assign we_match   = (mem_we_q == mem_we_ack);
  // Only the low 10 bits of the image size matter: a copier header leaves size % 1024 == 512
  assign header_hit = (byte_cnt_q == 10'd512);
  assign addr_lo    = ioctl_addr[AW-1:0];
  assign addr_m512  = addr_lo - AW'(512);
  assign rd_off     = rom_addr - AW'(512);

  assign ioctl_wait = ioctl_wait_q;
  assign mem_waddr  = mem_waddr_q;
  assign mem_din    = mem_din_q;
  assign mem_we     = mem_we_q;
  assign gg         = gg_q;
  assign header     = header_q;
  assign load_done  = load_done_q;
  assign mem_raddr  = header_q ? (rd_off & cart_mask512_q) : (rom_addr & cart_mask_q);

  // State register
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) state_q <= S_DRAIN;
    else       state_q <= state_d;
  end

  // Next-state and per-cycle strobes for the datapath
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    accept  = 1'b0;
    acked   = 1'b0;
    finish  = 1'b0;
    case (state_q)
      S_DRAIN: if (we_match) state_d = S_IDLE;
      S_IDLE: begin
        if (dl_rise) begin
          start   = 1'b1;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (ioctl_wr && cart_dl) begin
          accept  = 1'b1;
          state_d = S_ACK;
        end else if (dl_fall) begin
          state_d = S_FINISH;
        end
      end
      S_ACK: begin
        if (we_match) begin
          acked   = 1'b1;
          state_d = (fall_pend_q || dl_fall) ? S_FINISH : S_LOAD;
        end
      end
      S_FINISH: begin
        finish  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_DRAIN;
    endcase
  end

  // Request toggle has no reset so an in-flight request stays paired with its ack
  always_ff @(posedge clk_sys) begin
    if (accept) mem_we_q <= ~mem_we_q;
  end

  // Download datapath: addresses, data, masks, header and completion pulse
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      cart_dl_q      <= 1'b0;
      ioctl_wait_q   <= 1'b0;
      mem_waddr_q    <= '0;
      mem_din_q      <= '0;
      gg_q           <= 1'b0;
      header_q       <= 1'b0;
      load_done_q    <= 1'b0;
      cart_mask_q    <= '0;
      cart_mask512_q <= '0;
      byte_cnt_q     <= '0;
      fall_pend_q    <= 1'b0;
    end else begin
      cart_dl_q   <= cart_dl;
      load_done_q <= 1'b0;
      if (start || acked)                 fall_pend_q <= 1'b0;
      else if (state_q == S_ACK && dl_fall) fall_pend_q <= 1'b1;
      if (start) begin
        mem_waddr_q <= '0;
        byte_cnt_q  <= '0;
        header_q    <= 1'b0;
      end
      if (accept) begin
        mem_din_q      <= ioctl_dout;
        ioctl_wait_q   <= 1'b1;
        byte_cnt_q     <= ioctl_addr[9:0] + 10'd1;
        gg_q           <= (ioctl_index[4:0] == GG_IDX);
        cart_mask_q    <= (ioctl_addr == 25'd0)   ? '0 : (cart_mask_q | addr_lo);
        cart_mask512_q <= (ioctl_addr == 25'd512) ? '0 : (cart_mask512_q | addr_m512);
      end
      if (acked) begin
        ioctl_wait_q <= 1'b0;
        mem_waddr_q  <= mem_waddr_q + AW'(1);
      end
      if (finish) begin
        header_q    <= header_hit;
        load_done_q <= 1'b1;
      end
    end
  end

`ifdef CART_LOADER_CHECKSUM_EN
  logic [15:0] sum_all_q, sum_hdr_q, checksum_q;

  // Sum over every byte and over the post-header part; FINISH keeps the one matching the header result
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      sum_all_q  <= '0;
      sum_hdr_q  <= '0;
      checksum_q <= '0;
    end else begin
      if (start) begin
        sum_all_q <= '0;
        sum_hdr_q <= '0;
      end
      if (accept) begin
        sum_all_q <= sum_all_q + {8'd0, ioctl_dout};
        if (ioctl_addr >= 25'd512) sum_hdr_q <= sum_hdr_q + {8'd0, ioctl_dout};
      end
      if (finish) checksum_q <= header_hit ? sum_hdr_q : sum_all_q;
    end
  end

  assign checksum = checksum_q;
`endif

endmodule

// File: doc/cart_loader.md
Name: cart_loader

Overview:
- Sits between the hps_io ioctl download stream and the sdram write port.
- Accepts ROM bytes from the HPS and issues one sdram write per byte using a toggle req/ack handshake, throttling the HPS with ioctl_wait.
- Tracks the image size, detects a 512-byte copier header and derives the address masks.
- Provides the masked/offset cartridge read address consumed by the sdram read port.

Parameters:
- AW, 22, sdram byte address width; also the width of the cart masks.
- CODE_IDX, 8'd3, ioctl_index value reserved for cheat codes; ignored by this block.
- GG_IDX, 5'd2, ioctl_index[4:0] value that marks a Game Gear image.

Ports:
- clk_sys  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- ioctl_download  in  1  download window active.
- ioctl_index  in  8  download type.
- ioctl_wr  in  1  single-cycle byte strobe.
- ioctl_addr  in  25  byte offset within the image.
- ioctl_dout  in  8  byte data.
- ioctl_wait  out  1  stall request to hps_io.
- mem_waddr  out  AW  sdram write address.
- mem_din  out  8  sdram write data.
- mem_we  out  1  write request toggle.
- mem_we_ack  in  1  sdram acknowledge toggle.
- rom_addr  in  AW  unmasked system ROM read address.
- mem_raddr  out  AW  translated sdram read address.
- cart_dl  out  1  ioctl_download & (ioctl_index != CODE_IDX).
- gg  out  1  latched Game Gear flag.
- header  out  1  512-byte header present.
- load_done  out  1  one-cycle pulse after the last write of a download is acknowledged.

Behaviour:
- Reset values: ioctl_wait=0, mem_waddr=0, mem_din=0, gg=0, header=0, load_done=0, cart_mask=0, cart_mask512=0, byte_cnt=0, state=DRAIN.
- mem_we is not reset: its value is preserved so the toggle pair stays consistent.
- States:
  - DRAIN: wait until mem_we==mem_we_ack, then go to IDLE. This absorbs a write that was in flight when reset arrived.
  - IDLE:
    - On a rising edge of cart_dl: mem_waddr<=0, byte_cnt<=0, header<=0, go to LOAD.
  - LOAD:
    - On ioctl_wr & cart_dl: mem_din<=ioctl_dout, mem_we<=~mem_we, ioctl_wait<=1, byte_cnt<=ioctl_addr+1, go to ACK.
    - On a falling edge of cart_dl: go to FINISH.
  - ACK:
    - When mem_we==mem_we_ack: ioctl_wait<=0, mem_waddr<=mem_waddr+1 (wraps at 2^AW), return to LOAD.
    - ioctl_wr arriving in ACK is a protocol violation and is ignored.
    - A falling edge of cart_dl in ACK is remembered; after the ack, go to FINISH instead of LOAD.
  - FINISH (one cycle): header<=(byte_cnt[9:0]==10'd512), load_done<=1, go to IDLE.
- Write latency: mem_we toggles one cycle after ioctl_wr. ioctl_wait is high from the cycle after ioctl_wr until the cycle after the matching ack. Minimum 3 cycles per byte.
- Masks, updated on every accepted byte:
  - cart_mask |= ioctl_addr[AW-1:0]; cleared to 0 when ioctl_addr==0.
  - cart_mask512 |= (ioctl_addr[AW-1:0]-512); cleared to 0 when ioctl_addr==512.
- gg <= (ioctl_index[4:0]==GG_IDX) on every accepted byte.
- Read translation (combinational):
  - mem_raddr = header ? ((rom_addr-512) & cart_mask512) : (rom_addr & cart_mask).
  - Subtraction is modulo 2^AW.
- Downloads with ioctl_index==CODE_IDX: no writes, ioctl_wait stays 0, masks/header/gg unchanged.
- Reset mid-transfer: ioctl_wait drops immediately; the block enters DRAIN and needs a new download to reload.
- Zero-byte download: FINISH reports header=0, masks are left unchanged, load_done still pulses.

Optional Feature:
- Macro: CART_LOADER_CHECKSUM_EN.
- When defined:
  - Adds output port checksum [15:0]: the 16-bit modulo sum of all accepted bytes, excluding the first 512 bytes when header is finally 1.
  - Two accumulators run, one over all bytes and one over bytes at ioctl_addr>=512. The one selected by the header result is registered to checksum in FINISH. Reset value is 0.
- When undefined: the port and accumulators are absent; all other behaviour is identical.

Test Plan:
- Write 1024 bytes (index 1), ack 2 cycles after each toggle:
  - 1024 toggles; mem_waddr 0..1023 with data matching the stream.
  - header=0, cart_mask=0x3FF, load_done pulses once.
  - rom_addr=0x1405 -> mem_raddr=0x005.
- Write a 1536-byte image (index 1):
  - header=1, cart_mask512=0x3FF.
  - rom_addr=0x205 -> mem_raddr=0x005; rom_addr=0x1FF -> mem_raddr=0x3FF.
- Hold ack for 20 cycles on byte 5:
  - ioctl_wait stays 1 for the full stall.
  - An extra ioctl_wr pulse inside the stall produces no toggle and does not change mem_waddr.
- Assert reset after byte 100's toggle with ack still pending:
  - ioctl_wait=0 immediately; mem_we keeps its value.
  - State stays in DRAIN until ack matches, then IDLE; a new download restarts at mem_waddr=0.
- Download with index 3 (16 bytes): no mem_we toggles, ioctl_wait=0 throughout, masks/gg unchanged, cart_dl=0.
- Index 2 download: gg=1. With CART_LOADER_CHECKSUM_EN, a 1536-byte image of all 0x01: checksum=0x0400 (the 1024 bytes after the header).
